// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 block.
//   Register indices as seen by mfc0/mtc0, bit positions of the SR/Cause
//   fields, ExcCode values, and the mtc0 write-request struct.
package cp0_pkg;

    // CP0 register indices (rd field of mfc0/mtc0)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    // Field positions
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_BASE  = 10;   // IM in SR and IP in Cause share this base
    localparam int EXC_LO   = 2;
    localparam int EXC_HI   = 6;
    localparam int CAUSE_BD = 31;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // mtc0 write request after gating by int_req
    typedef struct packed {
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
    } cp0_wr_t;

endpackage

// File: rtl/cp0_count_timer.sv
// cp0_count_timer: Count/Compare timer for CP0.
//   Count increments every cycle (free-running, wraps) unless loaded by mtc0.
//   Compare is loaded by mtc0; loading it clears the pending flag.
//   pending is sticky: set on any cycle where Count == Compare.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   we_count     load Count from din this edge
//   we_compare   load Compare from din this edge (clears pending)
//   din          write data
//   count        current Count value
//   compare      current Compare value
//   pending      sticky timer interrupt request
module cp0_count_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] din,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        pending
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            pending <= 1'b0;
        end else begin
            count <= we_count ? din : count + 32'd1;
            if (we_compare) begin
                compare <= din;
                pending <= 1'b0;
            end else if (count == compare) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 for the 5-stage MIPS core.
//   Holds SR/Cause/EPC/PRId, samples the HW interrupt lines, arbitrates an
//   interrupt against an M-stage exception and raises int_req to flush the
//   pipeline. Serves mfc0/mtc0 at M and clears EXL on eret.
//   Optional Count/Compare timer when CP0_COUNT_EN is defined; the timer
//   pending flag is ORed into the highest IP bit.
// Parameters:
//   NUM_HWINT  number of HW interrupt lines (1..6), IP/IM bits [9+NUM_HWINT:10]
//   PRID       read-only PRId value
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   a_rd        mfc0 register index        dout  mfc0 read data
//   a_wr, din   mtc0 index / data          we    mtc0 write enable
//   pc, bd      M-stage PC / delay-slot    exc_code  M-stage ExcCode, 0 = none
//   hw_int      level interrupt lines      eret  eret retiring
//   int_req     take exception/interrupt   irp   int_req caused by interrupt
//   exl         SR.EXL                     epc   EPC for eret redirect
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID      = 32'h2021_0007
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           a_rd,
    input  logic [4:0]           a_wr,
    input  logic [31:0]          din,
    input  logic                 we,
    input  logic [31:0]          pc,
    input  logic                 bd,
    input  logic [4:0]           exc_code,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 eret,
    output logic                 int_req,
    output logic                 irp,
    output logic                 exl,
    output logic [31:0]          epc,
    output logic [31:0]          dout
);

    localparam int IM_HI = IM_BASE + NUM_HWINT - 1;

    logic                 sr_ie;
    logic                 sr_exl;
    logic [NUM_HWINT-1:0] sr_im;
    logic [NUM_HWINT-1:0] ip_q;
    logic [NUM_HWINT-1:0] ip_eff;
    logic [4:0]           cause_exc;
    logic                 cause_bd;
    logic [31:0]          epc_q;
    logic                 int_pend;
    logic                 exc_pend;
    cp0_wr_t              wr;
    logic [31:0]          sr_word;
    logic [31:0]          cause_word;

    // A request in the same cycle wins over mtc0: the write is dropped.
    always_comb begin
        wr.we   = we & ~int_req;
        wr.idx  = a_wr;
        wr.data = din;
    end

`ifdef CP0_COUNT_EN
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 timer_pend;
    logic [NUM_HWINT-1:0] timer_mask;

    cp0_count_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .we_count   (wr.we && (wr.idx == REG_COUNT)),
        .we_compare (wr.we && (wr.idx == REG_COMPARE)),
        .din        (wr.data),
        .count      (count),
        .compare    (compare),
        .pending    (timer_pend)
    );

    // Timer shares the top IP line with the highest HW interrupt.
    always_comb begin
        timer_mask                = '0;
        timer_mask[NUM_HWINT-1]   = timer_pend;
    end
    assign ip_eff = ip_q | timer_mask;
`else
    assign ip_eff = ip_q;
`endif

    // EXL masks both sources; IE only masks interrupts.
    assign int_pend = sr_ie & ~sr_exl & (|(ip_eff & sr_im));
    assign exc_pend = ~sr_exl & (|exc_code);
    assign int_req  = int_pend | exc_pend;
    assign irp      = int_pend;
    assign exl      = sr_exl;

    // Forward a same-cycle mtc0 EPC so an eret retiring with it jumps right.
    assign epc = (wr.we && (wr.idx == REG_EPC)) ? wr.data : epc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_ie     <= 1'b0;
            sr_exl    <= 1'b0;
            sr_im     <= '0;
            ip_q      <= '0;
            cause_exc <= EXC_INT;
            cause_bd  <= 1'b0;
            epc_q     <= 32'd0;
        end else begin
            ip_q <= hw_int;     // not sticky: follows line level
            if (int_req) begin
                sr_exl    <= 1'b1;
                cause_exc <= int_pend ? EXC_INT : exc_code;
                cause_bd  <= bd;
                epc_q     <= bd ? (pc - 32'd4) : pc;
            end else begin
                if (wr.we && (wr.idx == REG_SR)) begin
                    sr_ie  <= wr.data[SR_IE];
                    sr_exl <= wr.data[SR_EXL];
                    sr_im  <= wr.data[IM_HI:IM_BASE];
                end
                if (wr.we && (wr.idx == REG_EPC))
                    epc_q <= wr.data;
                // eret overrides an EXL value written by a coincident mtc0
                if (eret)
                    sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        sr_word                   = 32'd0;
        sr_word[SR_IE]            = sr_ie;
        sr_word[SR_EXL]           = sr_exl;
        sr_word[IM_HI:IM_BASE]    = sr_im;
    end

    always_comb begin
        cause_word                 = 32'd0;
        cause_word[EXC_HI:EXC_LO]  = cause_exc;
        cause_word[IM_HI:IM_BASE]  = ip_eff;
        cause_word[CAUSE_BD]       = cause_bd;
    end

    always_comb begin
        dout = 32'd0;
        case (a_rd)
            REG_SR:      dout = sr_word;
            REG_CAUSE:   dout = cause_word;
            REG_EPC:     dout = epc_q;
            REG_PRID:    dout = PRID;
`ifdef CP0_COUNT_EN
            REG_COUNT:   dout = count;
            REG_COMPARE: dout = compare;
`endif
            default:     dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: self-checking bench for cp0_unit (NUM_HWINT=6).
//   Each cycle the bench drives inputs and queues the outputs it expects for
//   that cycle; the queue is drained at the falling edge and each entry
//   compared against the DUT. Timer scenario is included when CP0_COUNT_EN
//   is defined for the build.
module tb_cp0_unit;
    import cp0_pkg::*;

    localparam int S_INT  = 0;
    localparam int S_IRP  = 1;
    localparam int S_EXL  = 2;
    localparam int S_EPC  = 3;
    localparam int S_DOUT = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  a_rd;
    logic [4:0]  a_wr;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        int_req;
    logic        irp;
    logic        exl;
    logic [31:0] epc;
    logic [31:0] dout;

    cp0_unit #(.NUM_HWINT(6), .PRID(32'h2021_0007)) dut (
        .clk(clk), .reset(reset), .a_rd(a_rd), .a_wr(a_wr), .din(din),
        .we(we), .pc(pc), .bd(bd), .exc_code(exc_code), .hw_int(hw_int),
        .eret(eret), .int_req(int_req), .irp(irp), .exl(exl), .epc(epc),
        .dout(dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [4:0]  rd;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic push_out(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.rd = 5'd0; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_rd(input string tag, input logic [4:0] rd, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = S_DOUT; e.rd = rd; e.exp = exp;
        sb.push_back(e);
    endtask

    // Compare every queued expectation against the DUT at the falling edge.
    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = 32'd0;
            case (e.sel)
                S_INT:   got = {31'd0, int_req};
                S_IRP:   got = {31'd0, irp};
                S_EXL:   got = {31'd0, exl};
                S_EPC:   got = epc;
                default: begin a_rd = e.rd; #1; got = dout; end
            endcase
            chk(e.tag, got, e.exp);
        end
    endtask

    task automatic tick();
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        we = 1'b0; exc_code = 5'd0; bd = 1'b0; eret = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        we = 1'b1; a_wr = r; din = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; idle_in();
        a_rd = 5'd0; a_wr = 5'd0; din = 32'd0; pc = 32'd0; hw_int = 6'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        push_out("rst_int", S_INT, 0);
        push_out("rst_irp", S_IRP, 0);
        push_out("rst_exl", S_EXL, 0);
        push_out("rst_epc", S_EPC, 0);
        push_rd ("rst_sr",    REG_SR,    32'h0);
        push_rd ("rst_cause", REG_CAUSE, 32'h0);
        push_rd ("rst_prid",  REG_PRID,  32'h2021_0007);
        tick();

`ifdef CP0_COUNT_EN
        // Count==Compare==0 right after reset latches pending; park Compare.
        mtc0(REG_COMPARE, 32'hFFFF_FFFF);
        tick();
        idle_in();
`endif

        // 1: enable line 0, assert it; request appears one cycle later
        mtc0(REG_SR, 32'h0000_0401); hw_int = 6'b000001; pc = 32'h3010;
        push_out("t1_int_wr", S_INT, 0);
        tick();
        idle_in();
        push_out("t1_int", S_INT, 1);
        push_out("t1_irp", S_IRP, 1);
        tick();

        // 3: in handler, exception and live line are both masked by EXL
        exc_code = EXC_ADEL; pc = 32'h3030;
        push_out("t1_exl",   S_EXL, 1);
        push_rd ("t1_cause", REG_CAUSE, 32'h0000_0400);
        push_rd ("t1_epcr",  REG_EPC,   32'h0000_3010);
        push_out("t1_epc",   S_EPC, 32'h3010);
        push_out("t3_int0",  S_INT, 0);
        tick();
        exc_code = EXC_ADES;
        push_out("t3_int1",  S_INT, 0);
        push_rd ("t3_cause", REG_CAUSE, 32'h0000_0400);
        push_rd ("t3_epcr",  REG_EPC,   32'h0000_3010);
        tick();
        exc_code = 5'd0; eret = 1'b1;
        push_out("t3_eret_int", S_INT, 0);
        push_out("t3_eret_exl", S_EXL, 1);
        tick();
        eret = 1'b0; pc = 32'h3040; hw_int = 6'd0;
        push_out("t3_exl0", S_EXL, 0);
        push_out("t3_int",  S_INT, 1);
        push_out("t3_irp",  S_IRP, 1);
        tick();

        // 4: mtc0 EPC with eret forwards to epc output the same cycle
        mtc0(REG_EPC, 32'h0000_3400); eret = 1'b1;
        push_rd ("t4_epc_pre", REG_EPC, 32'h0000_3040);
        push_out("t4_epc_fwd", S_EPC, 32'h3400);
        push_out("t4_int",     S_INT, 0);
        tick();
        idle_in();
        push_out("t4_epc",   S_EPC, 32'h3400);
        push_rd ("t4_epcr",  REG_EPC, 32'h0000_3400);
        push_out("t4_exl",   S_EXL, 0);
        push_out("t4_int_q", S_INT, 0);
        tick();

        // 2: overflow in delay slot, IE clear
        mtc0(REG_SR, 32'h0);
        push_out("t2_int_wr", S_INT, 0);
        tick();
        idle_in(); exc_code = EXC_OV; bd = 1'b1; pc = 32'h3020;
        push_out("t2_int", S_INT, 1);
        push_out("t2_irp", S_IRP, 0);
        tick();
        idle_in(); eret = 1'b1;
        push_out("t2_exl",   S_EXL, 1);
        push_rd ("t2_cause", REG_CAUSE, 32'h8000_0030);
        push_rd ("t2_epcr",  REG_EPC,   32'h0000_301C);
        push_out("t2_epc",   S_EPC, 32'h301C);
        push_out("t2_int0",  S_INT, 0);
        tick();

        // 5: mtc0 SR coincident with RI: write dropped, RI recorded
        idle_in(); mtc0(REG_SR, 32'hFFFF_FFFF); exc_code = EXC_RI; pc = 32'h3050;
        push_out("t5_exl0", S_EXL, 0);
        push_out("t5_int",  S_INT, 1);
        push_out("t5_irp",  S_IRP, 0);
        tick();
        idle_in(); eret = 1'b1;
        push_rd("t5_sr",    REG_SR,    32'h0000_0002);
        push_rd("t5_cause", REG_CAUSE, 32'h0000_0028);
        push_rd("t5_epcr",  REG_EPC,   32'h0000_3050);
        tick();

        // SR field masking, Cause not writable, mtc0 SR + eret
        idle_in(); mtc0(REG_SR, 32'hFFFF_FFFF);
        push_out("sr_exl0", S_EXL, 0);
        push_out("sr_int0", S_INT, 0);
        tick();
        idle_in(); mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        push_rd ("sr_mask", REG_SR, 32'h0000_FC03);
        push_out("sr_exl1", S_EXL, 1);
        push_out("sr_int1", S_INT, 0);
        tick();
        idle_in(); mtc0(REG_SR, 32'h0); eret = 1'b1;
        push_rd("cause_ro", REG_CAUSE, 32'h0000_0028);
        tick();
        idle_in();
        push_rd ("sr_clr",  REG_SR, 32'h0);
        push_out("sr_exl2", S_EXL, 0);
        tick();

`ifdef CP0_COUNT_EN
        // 6: timer fires one cycle after Count reaches Compare
        begin
            int waited;
            mtc0(REG_COUNT, 32'd0);
            tick();
            mtc0(REG_COMPARE, 32'd10);
            tick();
            mtc0(REG_SR, 32'h0000_8001);
            tick();
            idle_in();
            waited = 0;
            while (!int_req && waited < 40) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("t6_seen", {31'd0, int_req}, 32'd1);
            push_out("t6_irp",   S_IRP, 1);
            push_rd ("t6_count", REG_COUNT, 32'd11);
            push_rd ("t6_cause", REG_CAUSE, 32'h0000_8028);
            tick();
            mtc0(REG_COMPARE, 32'd100);
            push_out("t6_int_h", S_INT, 0);
            tick();
            idle_in();
            push_rd ("t6_clr",  REG_CAUSE, 32'h0);
            push_rd ("t6_cmp",  REG_COMPARE, 32'd100);
            tick();
        end
`else
        // Timer registers absent: read 0, writes ignored
        mtc0(REG_COUNT, 32'd5);
        tick();
        mtc0(REG_COMPARE, 32'd5);
        push_rd("no_count", REG_COUNT, 32'd0);
        tick();
        idle_in();
        push_rd("no_cmp",  REG_COMPARE, 32'd0);
        push_rd("no_reg0", 5'd0, 32'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
